// File: rtl/qoi_pkg.sv
// Shared definitions for the QOI pixel input block: register map, CTRL/STATUS bit positions
// and the packed pixel type.
package qoi_pkg;

   localparam logic [1:0] AddrData   = 2'd0;
   localparam logic [1:0] AddrCtrl   = 2'd1;
   localparam logic [1:0] AddrStatus = 2'd2;
   localparam logic [1:0] AddrLevel  = 2'd3;

   localparam int unsigned CtrlCh4Bit   = 0;
   localparam int unsigned CtrlClearBit = 1;
   localparam int unsigned CtrlLastBit  = 2;

   localparam int unsigned StatFullBit    = 0;
   localparam int unsigned StatEmptyBit   = 1;
   localparam int unsigned StatPartialBit = 2;
   localparam int unsigned StatOvfBit     = 3;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic [7:0] a;
   } pixel_t;

   // FIFO entry is the pixel plus its last-of-image flag.
   localparam int unsigned PixFifoWidth = $bits(pixel_t) + 1;

endpackage

// File: rtl/qoi_pix_fifo.sv
// Four-entry FIFO with 2-bit wrapping pointers, a separate 0..4 level counter and a
// synchronous clear. A push into a full FIFO is accepted only alongside a pop.
module qoi_pix_fifo #(
   parameter int unsigned Width = 33
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [Width-1:0] wdata_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [2:0]       level_o
);

   logic [Width-1:0] mem_q [4];
   logic [Width-1:0] mem_d [4];
   logic [1:0]       wr_ptr_q, wr_ptr_d;
   logic [1:0]       rd_ptr_q, rd_ptr_d;
   logic [2:0]       level_q, level_d;
   logic             do_push, do_pop;

   assign full_o  = (level_q == 3'd4);
   assign empty_o = (level_q == 3'd0);
   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

   always_comb begin
      do_pop   = pop_i & ~empty_o;
      do_push  = push_i & (~full_o | do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clr_i) begin
         wr_ptr_d = 2'd0;
         rd_ptr_d = 2'd0;
         level_d  = 3'd0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + 2'd1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
         end
         level_d = level_q + {2'b00, do_push} - {2'b00, do_pop};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 4; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         level_q  <= 3'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/qoi_pixel_in.sv
// CPU byte-register front end assembling RGB(A) pixels into a FIFO feeding a QOI encoder.
// 4-channel (alpha) mode is available only when QOI_PIXIN_ALPHA_EN is defined.
module qoi_pixel_in
   import qoi_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [7:0]  data_i,
   output logic [7:0]  data_o,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [31:0] pix_data,
   output logic        pix_last
);

   logic [1:0]              chan_q, chan_d;
   pixel_t                  pix_q, pix_d;
   logic                    ch4_q, ch4_d;
   logic                    last_q, last_d;
   logic                    ovf_q, ovf_d;

   logic                    data_wr, ctrl_wr, ctrl_clear, ch4_new;
   logic [1:0]              last_chan;
   pixel_t                  pix_asm;
   logic                    push_req, push_ok, pop;
   logic                    fifo_full, fifo_empty;
   logic [2:0]              fifo_level;
   logic [PixFifoWidth-1:0] fifo_rdata;

   assign pop = pix_valid & pix_ready;

   always_comb begin
      data_wr    = cs & we & (addr == AddrData);
      ctrl_wr    = cs & we & (addr == AddrCtrl);
      ctrl_clear = ctrl_wr & data_i[CtrlClearBit];
`ifdef QOI_PIXIN_ALPHA_EN
      ch4_new = data_i[CtrlCh4Bit];
`else
      ch4_new = 1'b0;
`endif
      last_chan = ch4_q ? 2'd3 : 2'd2;

      pix_asm = pix_q;
      case (chan_q)
         2'd0:    pix_asm.r = data_i;
         2'd1:    pix_asm.g = data_i;
         2'd2:    pix_asm.b = data_i;
         default: pix_asm.a = data_i;
      endcase
      if (!ch4_q) begin
         pix_asm.a = 8'hFF;
      end

      push_req = data_wr & (chan_q == last_chan);
      push_ok  = push_req & (~fifo_full | pop);

      chan_d = chan_q;
      pix_d  = pix_q;
      ch4_d  = ch4_q;
      last_d = last_q;
      ovf_d  = ovf_q;

      if (data_wr) begin
         pix_d  = pix_asm;
         chan_d = push_req ? 2'd0 : chan_q + 2'd1;
      end
      // A dropped pixel keeps LAST armed for the next pixel that actually lands.
      if (push_req && !push_ok) begin
         ovf_d = 1'b1;
      end
      if (push_ok) begin
         last_d = 1'b0;
      end

      if (ctrl_wr) begin
         ch4_d = ch4_new;
         if (ch4_new != ch4_q) begin
            chan_d = 2'd0;
         end
         if (ctrl_clear) begin
            chan_d = 2'd0;
            ovf_d  = 1'b0;
            last_d = 1'b0;
         end else if (data_i[CtrlLastBit]) begin
            last_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chan_q <= 2'd0;
         pix_q  <= '0;
         ch4_q  <= 1'b0;
         last_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         chan_q <= chan_d;
         pix_q  <= pix_d;
         ch4_q  <= ch4_d;
         last_q <= last_d;
         ovf_q  <= ovf_d;
      end
   end

   qoi_pix_fifo #(
      .Width(PixFifoWidth)
   ) u_fifo (
      .clk_i  (clk),
      .rst_i  (rst),
      .clr_i  (ctrl_clear),
      .push_i (push_req),
      .pop_i  (pop),
      .wdata_i({pix_asm, last_q}),
      .rdata_o(fifo_rdata),
      .full_o (fifo_full),
      .empty_o(fifo_empty),
      .level_o(fifo_level)
   );

   // Outputs are gated so nothing leaks out during reset or while the FIFO is empty.
   assign pix_valid = ~fifo_empty & ~rst;
   assign pix_data  = pix_valid ? fifo_rdata[PixFifoWidth-1:1] : 32'h0;
   assign pix_last  = pix_valid & fifo_rdata[0];

   always_comb begin
      data_o = 8'h00;
      case (addr)
         AddrCtrl: begin
            data_o[CtrlLastBit] = last_q;
            data_o[CtrlCh4Bit]  = ch4_q;
         end
         AddrStatus: begin
            data_o[StatOvfBit]     = ovf_q;
            data_o[StatPartialBit] = (chan_q != 2'd0);
            data_o[StatEmptyBit]   = fifo_empty;
            data_o[StatFullBit]    = fifo_full;
         end
         AddrLevel: data_o = {5'b00000, fifo_level};
         default:   data_o = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_qoi_pixel_in.sv
// Directed bench for qoi_pixel_in: a vector table for the basic data path plus hand-written
// sequences for overflow, full-with-pop, LAST/CLEAR, reset and the alpha option.
module tb_qoi_pixel_in;

   logic        clk;
   logic        rst;
   logic        cs;
   logic        we;
   logic [1:0]  addr;
   logic [7:0]  data_i;
   logic [7:0]  data_o;
   logic        pix_valid;
   logic        pix_ready;
   logic [31:0] pix_data;
   logic        pix_last;

   int errors = 0;
   int checks = 0;

   qoi_pixel_in dut (
      .clk      (clk),
      .rst      (rst),
      .cs       (cs),
      .we       (we),
      .addr     (addr),
      .data_i   (data_i),
      .data_o   (data_o),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready),
      .pix_data (pix_data),
      .pix_last (pix_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  addr;
      logic [7:0]  wdata;
      logic        ready;
      logic        exp_valid;
      logic [31:0] exp_pix;
      logic [2:0]  exp_level;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic rdy);
      @(negedge clk);
      cs = 1'b1; we = 1'b1; addr = a; data_i = d; pix_ready = rdy;
      @(posedge clk);
      #1;
      cs = 1'b0; we = 1'b0; pix_ready = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      addr = a;
      #1;
      d = data_o;
   endtask

   task automatic do_pop();
      @(negedge clk);
      pix_ready = 1'b1;
      @(posedge clk);
      #1;
      pix_ready = 1'b0;
   endtask

   function automatic logic [31:0] px(input int k);
      return {8'(k), 8'(k + 16), 8'(k + 32), 8'hFF};
   endfunction

   // Last byte may be written with pix_ready high to pop on the completing edge.
   task automatic wr_px(input int k, input logic rdy_last);
      logic [31:0] p;
      p = px(k);
      wr(2'd0, p[31:24], 1'b0);
      wr(2'd0, p[23:16], 1'b0);
      wr(2'd0, p[15:8], rdy_last);
   endtask

   task automatic drain(input string tag, input int first, input int n);
      for (int k = first; k < first + n; k++) begin
         check({tag, " valid"}, {31'b0, pix_valid}, 32'd1);
         check({tag, " order"}, pix_data, px(k));
         do_pop();
      end
      check({tag, " empty"}, {31'b0, pix_valid}, 32'd0);
   endtask

   logic [7:0] d;

   initial begin
      vecs[0]  = '{2'd0, 8'h12, 1'b0, 1'b0, 32'h0,        3'd0};
      vecs[1]  = '{2'd0, 8'h34, 1'b0, 1'b0, 32'h0,        3'd0};
      vecs[2]  = '{2'd0, 8'h56, 1'b0, 1'b1, 32'h123456FF, 3'd1};
      vecs[3]  = '{2'd0, 8'hAA, 1'b1, 1'b0, 32'h0,        3'd0};
      vecs[4]  = '{2'd0, 8'hBB, 1'b0, 1'b0, 32'h0,        3'd0};
      vecs[5]  = '{2'd0, 8'hCC, 1'b0, 1'b1, 32'hAABBCCFF, 3'd1};
      vecs[6]  = '{2'd0, 8'h01, 1'b0, 1'b1, 32'hAABBCCFF, 3'd1};
      vecs[7]  = '{2'd0, 8'h02, 1'b0, 1'b1, 32'hAABBCCFF, 3'd1};
      vecs[8]  = '{2'd0, 8'h03, 1'b0, 1'b1, 32'hAABBCCFF, 3'd2};
      vecs[9]  = '{2'd0, 8'h10, 1'b1, 1'b1, 32'h010203FF, 3'd1};
      vecs[10] = '{2'd1, 8'h02, 1'b0, 1'b0, 32'h0,        3'd0};
      vecs[11] = '{2'd0, 8'h07, 1'b0, 1'b0, 32'h0,        3'd0};
      vecs[12] = '{2'd0, 8'h08, 1'b0, 1'b0, 32'h0,        3'd0};
      vecs[13] = '{2'd0, 8'h09, 1'b0, 1'b1, 32'h070809FF, 3'd1};

      rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 2'd0; data_i = 8'h00; pix_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst valid", {31'b0, pix_valid}, 32'd0);
      check("rst data", pix_data, 32'h0);
      check("rst last", {31'b0, pix_last}, 32'd0);
      rst = 1'b0;
      rd(2'd0, d); check("rst DATA", {24'b0, d}, 32'h00);
      rd(2'd1, d); check("rst CTRL", {24'b0, d}, 32'h00);
      rd(2'd2, d); check("rst STATUS", {24'b0, d}, 32'h02);
      rd(2'd3, d); check("rst LEVEL", {24'b0, d}, 32'h00);

      for (int i = 0; i < 14; i++) begin
         wr(vecs[i].addr, vecs[i].wdata, vecs[i].ready);
         check($sformatf("vec%0d valid", i), {31'b0, pix_valid}, {31'b0, vecs[i].exp_valid});
         check($sformatf("vec%0d data", i), pix_data, vecs[i].exp_pix);
         rd(2'd3, d);
         check($sformatf("vec%0d level", i), {24'b0, d}, {29'b0, vecs[i].exp_level});
      end

      // Overflow: five pixels with the encoder stalled.
      wr(2'd1, 8'h02, 1'b0);
      for (int k = 1; k <= 5; k++) wr_px(k, 1'b0);
      rd(2'd3, d); check("ovf LEVEL", {24'b0, d}, 32'h04);
      rd(2'd2, d); check("ovf STATUS", {24'b0, d}, 32'h09);
      drain("ovf", 1, 4);

      // Full FIFO with a pop on the completing edge.
      wr(2'd1, 8'h02, 1'b0);
      rd(2'd2, d); check("clr STATUS", {24'b0, d}, 32'h02);
      for (int k = 1; k <= 4; k++) wr_px(k, 1'b0);
      wr_px(5, 1'b1);
      rd(2'd3, d); check("fullpop LEVEL", {24'b0, d}, 32'h04);
      rd(2'd2, d); check("fullpop STATUS", {24'b0, d}, 32'h01);
      drain("fullpop", 2, 4);

      // LAST attaches to exactly one pixel, then CLEAR flushes a queue of three.
      wr(2'd1, 8'h02, 1'b0);
      wr(2'd1, 8'h04, 1'b0);
      rd(2'd1, d); check("last armed", {24'b0, d}, 32'h04);
      wr_px(1, 1'b0);
      rd(2'd1, d); check("last consumed", {24'b0, d}, 32'h00);
      wr_px(2, 1'b0);
      check("last px1 flag", {31'b0, pix_last}, 32'd1);
      check("last px1 data", pix_data, px(1));
      do_pop();
      check("last px2 flag", {31'b0, pix_last}, 32'd0);
      check("last px2 data", pix_data, px(2));
      wr_px(3, 1'b0);
      wr_px(4, 1'b0);
      rd(2'd3, d); check("preclr LEVEL", {24'b0, d}, 32'h03);
      wr(2'd1, 8'h02, 1'b0);
      rd(2'd3, d); check("clr LEVEL", {24'b0, d}, 32'h00);
      check("clr valid", {31'b0, pix_valid}, 32'd0);

      // Reset mid-pixel, overriding a simultaneous DATA write.
      wr(2'd0, 8'hAA, 1'b0);
      wr(2'd0, 8'hBB, 1'b0);
      rd(2'd2, d); check("partial STATUS", {24'b0, d}, 32'h06);
      @(negedge clk);
      rst = 1'b1; cs = 1'b1; we = 1'b1; addr = 2'd0; data_i = 8'hCC;
      @(posedge clk);
      #1;
      check("inrst valid", {31'b0, pix_valid}, 32'd0);
      check("inrst data", pix_data, 32'h0);
      rst = 1'b0; cs = 1'b0; we = 1'b0;
      rd(2'd2, d); check("postrst STATUS", {24'b0, d}, 32'h02);
      wr_px(1, 1'b0);
      check("fresh px data", pix_data, px(1));
      rd(2'd3, d); check("fresh LEVEL", {24'b0, d}, 32'h01);

      // Writes to STATUS and LEVEL have no effect.
      wr(2'd3, 8'hFF, 1'b0);
      wr(2'd2, 8'hFF, 1'b0);
      rd(2'd3, d); check("ro LEVEL", {24'b0, d}, 32'h01);
      rd(2'd2, d); check("ro STATUS", {24'b0, d}, 32'h00);

      wr(2'd1, 8'h02, 1'b0);
      wr(2'd1, 8'h01, 1'b0);
`ifdef QOI_PIXIN_ALPHA_EN
      rd(2'd1, d); check("ch4 CTRL", {24'b0, d}, 32'h01);
      wr(2'd0, 8'h01, 1'b0);
      wr(2'd0, 8'h02, 1'b0);
      wr(2'd0, 8'h03, 1'b0);
      rd(2'd2, d); check("ch4 partial", {24'(d[2])}, 32'd1);
      check("ch4 3byte valid", {31'b0, pix_valid}, 32'd0);
      wr(2'd0, 8'h04, 1'b0);
      check("ch4 data", pix_data, 32'h01020304);
`else
      rd(2'd1, d); check("noalpha CTRL", {24'b0, d}, 32'h00);
      wr(2'd0, 8'h01, 1'b0);
      wr(2'd0, 8'h02, 1'b0);
      wr(2'd0, 8'h03, 1'b0);
      check("noalpha valid", {31'b0, pix_valid}, 32'd1);
      check("noalpha data", pix_data, 32'h010203FF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
